// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The master drives operands and consumes results; the slave is the unit.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;
  logic             zf;
  logic             sf;

  modport master (
    output in_valid, op, cin, a, b, out_ready,
    input  in_ready, out_valid, s, co, ov, zf, sf
  );

  modport slave (
    input  in_valid, op, cin, a, b, out_ready,
    output in_ready, out_valid, s, co, ov, zf, sf
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined ADD/SUB/ADC/SBC unit. The carry chain is cut into STAGES segments
// of SEG bits; stage k adds segment k and registers it together with the
// still-unprocessed operand bits and the already-finished lower result bits,
// so a whole result leaves the last stage at once. WIDTH must be a multiple
// of STAGES. The whole pipe advances in lock-step whenever the output
// register is empty or being drained.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          rstn,
  addsub_pipe_if.slave  bus
);

  localparam int SEG = WIDTH / STAGES;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBC = 2'd3
  } op_e;

  // One pipeline slot: operands (a and the effective b'), partial result,
  // segment carry, running zero flag and the signed-overflow flag that only
  // becomes meaningful once the last segment has been added.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             z;
    logic             ov;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t entry_d;
  logic   advance;

  // Pipe entry: fold the SUB/SBC inversion and carry-in selection into b'/c0.
  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    entry_d       = '0;
    entry_d.valid = bus.in_valid;
    entry_d.a     = bus.a;
    entry_d.b     = bus.b;
    entry_d.z     = 1'b1;
    case (op_e'(bus.op))
      OP_ADD: begin entry_d.b = bus.b;  entry_d.c = 1'b0;    end
      OP_SUB: begin entry_d.b = ~bus.b; entry_d.c = 1'b1;    end
      OP_ADC: begin entry_d.b = bus.b;  entry_d.c = bus.cin; end
      OP_SBC: begin entry_d.b = ~bus.b; entry_d.c = bus.cin; end
      default: ;
    endcase
  end

  // Segment adders: stage k adds bits [k*SEG +: SEG] using the carry and
  // zero flag handed down by stage k-1 (or by the pipe entry for stage 0).
  always_comb begin
    stage_t         src;
    logic [SEG:0]   seg_sum;
    for (int k = 0; k < STAGES; k++) begin
      src     = (k == 0) ? entry_d : stage_q[(k == 0) ? 0 : k - 1];
      seg_sum = {1'b0, src.a[k*SEG +: SEG]} + {1'b0, src.b[k*SEG +: SEG]}
              + {{SEG{1'b0}}, src.c};
      stage_d[k]                = src;
      stage_d[k].s[k*SEG +: SEG] = seg_sum[SEG-1:0];
      stage_d[k].c              = seg_sum[SEG];
      stage_d[k].z              = src.z & (seg_sum[SEG-1:0] == '0);
      stage_d[k].ov             = (src.a[WIDTH-1] == src.b[WIDTH-1])
                                && (stage_d[k].s[WIDTH-1] != src.a[WIDTH-1]);
    end
  end

  // Stage registers: all slots move together on advance and hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: datapath slots are cleared too, because the visible result and
      // flags come straight from the last slot and must read 0 in reset.
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (advance) begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign advance       = !stage_q[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = stage_q[STAGES-1].valid;
  assign bus.s         = stage_q[STAGES-1].s;
  assign bus.co        = stage_q[STAGES-1].c;
  assign bus.ov        = stage_q[STAGES-1].ov;
  assign bus.zf        = stage_q[STAGES-1].z;
  assign bus.sf        = stage_q[STAGES-1].s[WIDTH-1];

endmodule
